// File: rtl/id_stage.sv
// RV32I decode stage: register file with write-through bypass, immediate generation,
// control decode, load-use hazard detection with a one-entry replay buffer, and ID/EX register.
module id_stage #(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_instr,
   input  logic            if_pred_taken,
   input  logic            if_valid,
   input  logic            hazard_flush,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_wdata,
   output logic            load_use_stall,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [31:0]     ex_instr,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [3:0]      ex_alu_op,
   output logic            ex_alu_src_imm,
   output logic            ex_alu_src_pc,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_reg_write,
   output logic            ex_is_branch,
   output logic            ex_is_jump,
   output logic            ex_pred_taken,
   output logic [2:0]      ex_funct3,
   output logic            ex_illegal
);

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OPIMM  = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_FENCE  = 7'b0001111,
      OPC_SYSTEM = 7'b1110011
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
      ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
      ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
   } alu_op_e;

   logic [XLEN-1:0] r_regs [32];

   logic            r_hold_valid;
   logic [XLEN-1:0] r_hold_pc;
   logic [31:0]     r_hold_instr;
   logic            r_hold_pred;

   logic [XLEN-1:0] w_pc;
   logic [31:0]     w_instr;
   logic            w_pred;
   logic            w_src_valid;
   logic [4:0]      w_rs1, w_rs2, w_rd;
   logic [2:0]      w_funct3;
   logic [XLEN-1:0] w_rs1_data, w_rs2_data;

   logic [31:0]     w_imm;
   alu_op_e         w_alu_op;
   logic            w_src_imm, w_src_pc, w_mem_read, w_mem_write, w_reg_write;
   logic            w_branch, w_jump, w_illegal, w_uses_rs1, w_uses_rs2;

   // Replayed instruction has priority: fetch has already moved on while stalled.
   assign w_src_valid = r_hold_valid | if_valid;
   assign w_pc        = r_hold_valid ? r_hold_pc    : if_pc;
   assign w_instr     = r_hold_valid ? r_hold_instr : if_instr;
   assign w_pred      = r_hold_valid ? r_hold_pred  : if_pred_taken;

   assign w_rd     = w_instr[11:7];
   assign w_funct3 = w_instr[14:12];
   assign w_rs1    = w_instr[19:15];
   assign w_rs2    = w_instr[24:20];

   always_comb begin
      w_rs1_data = r_regs[w_rs1];
      if (w_rs1 == 5'd0)
         w_rs1_data = '0;
      else if (wb_we && wb_rd == w_rs1)
         w_rs1_data = wb_wdata;
   end

   always_comb begin
      w_rs2_data = r_regs[w_rs2];
      if (w_rs2 == 5'd0)
         w_rs2_data = '0;
      else if (wb_we && wb_rd == w_rs2)
         w_rs2_data = wb_wdata;
   end

   always_comb begin
      w_imm       = '0;
      w_alu_op    = ALU_ADD;
      w_src_imm   = 1'b0;
      w_src_pc    = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      w_branch    = 1'b0;
      w_jump      = 1'b0;
      w_illegal   = 1'b0;
      w_uses_rs1  = 1'b0;
      w_uses_rs2  = 1'b0;
      case (opcode_e'(w_instr[6:0]))
         OPC_LUI: begin
            w_imm       = {w_instr[31:12], 12'b0};
            w_alu_op    = ALU_PASSB;
            w_src_imm   = 1'b1;
            w_reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            w_imm       = {w_instr[31:12], 12'b0};
            w_src_imm   = 1'b1;
            w_src_pc    = 1'b1;
            w_reg_write = 1'b1;
         end
         OPC_JAL: begin
            w_imm       = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                           w_instr[30:21], 1'b0};
            w_src_imm   = 1'b1;
            w_src_pc    = 1'b1;
            w_jump      = 1'b1;
            w_reg_write = 1'b1;
         end
         OPC_JALR: begin
            w_imm       = {{20{w_instr[31]}}, w_instr[31:20]};
            w_src_imm   = 1'b1;
            w_jump      = 1'b1;
            w_reg_write = 1'b1;
            w_uses_rs1  = 1'b1;
         end
         OPC_BRANCH: begin
            w_imm      = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                          w_instr[11:8], 1'b0};
            w_alu_op   = ALU_SUB;
            w_branch   = 1'b1;
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
         end
         OPC_LOAD: begin
            w_imm       = {{20{w_instr[31]}}, w_instr[31:20]};
            w_src_imm   = 1'b1;
            w_mem_read  = 1'b1;
            w_reg_write = 1'b1;
            w_uses_rs1  = 1'b1;
         end
         OPC_STORE: begin
            w_imm       = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            w_src_imm   = 1'b1;
            w_mem_write = 1'b1;
            w_uses_rs1  = 1'b1;
            w_uses_rs2  = 1'b1;
         end
         OPC_OPIMM, OPC_OP: begin
            if (w_instr[5]) begin
               w_uses_rs2 = 1'b1;
            end else begin
               w_imm     = {{20{w_instr[31]}}, w_instr[31:20]};
               w_src_imm = 1'b1;
            end
            w_reg_write = 1'b1;
            w_uses_rs1  = 1'b1;
            case (w_funct3)
               3'b000:  w_alu_op = (w_instr[5] && w_instr[30]) ? ALU_SUB : ALU_ADD;
               3'b001:  w_alu_op = ALU_SLL;
               3'b010:  w_alu_op = ALU_SLT;
               3'b011:  w_alu_op = ALU_SLTU;
               3'b100:  w_alu_op = ALU_XOR;
               3'b101:  w_alu_op = w_instr[30] ? ALU_SRA : ALU_SRL;
               3'b110:  w_alu_op = ALU_OR;
               default: w_alu_op = ALU_AND;
            endcase
         end
         OPC_FENCE, OPC_SYSTEM: begin
            w_uses_rs1 = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
      if (w_rd == 5'd0)
         w_reg_write = 1'b0;
   end

   assign load_use_stall = w_src_valid & ~hazard_flush & ex_valid & ex_mem_read &
                           (ex_rd != 5'd0) &
                           ((w_uses_rs1 & (w_rs1 == ex_rd)) | (w_uses_rs2 & (w_rs2 == ex_rd)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 32; i++)
            r_regs[i] <= '0;
      end else if (wb_we && wb_rd != 5'd0) begin
         r_regs[wb_rd] <= wb_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_valid <= 1'b0;
         r_hold_pc    <= '0;
         r_hold_instr <= '0;
         r_hold_pred  <= 1'b0;
      end else if (hazard_flush) begin
         r_hold_valid <= 1'b0;
      end else if (load_use_stall) begin
         r_hold_valid <= 1'b1;
         r_hold_pc    <= w_pc;
         r_hold_instr <= w_instr;
         r_hold_pred  <= w_pred;
      end else if (w_src_valid) begin
         r_hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset || hazard_flush || load_use_stall || !w_src_valid) begin
         ex_valid       <= 1'b0;
         ex_pc          <= '0;
         ex_instr       <= NOP_INSTR;
         ex_rs1_data    <= '0;
         ex_rs2_data    <= '0;
         ex_imm         <= '0;
         ex_rs1         <= '0;
         ex_rs2         <= '0;
         ex_rd          <= '0;
         ex_alu_op      <= '0;
         ex_alu_src_imm <= 1'b0;
         ex_alu_src_pc  <= 1'b0;
         ex_mem_read    <= 1'b0;
         ex_mem_write   <= 1'b0;
         ex_reg_write   <= 1'b0;
         ex_is_branch   <= 1'b0;
         ex_is_jump     <= 1'b0;
         ex_pred_taken  <= 1'b0;
         ex_funct3      <= '0;
         ex_illegal     <= 1'b0;
      end else begin
         ex_valid       <= 1'b1;
         ex_pc          <= w_pc;
         ex_instr       <= w_instr;
         ex_rs1_data    <= w_rs1_data;
         ex_rs2_data    <= w_rs2_data;
         ex_imm         <= XLEN'($signed(w_imm));
         ex_rs1         <= w_rs1;
         ex_rs2         <= w_rs2;
         ex_rd          <= w_rd;
         ex_alu_op      <= w_alu_op;
         ex_alu_src_imm <= w_src_imm;
         ex_alu_src_pc  <= w_src_pc;
         ex_mem_read    <= w_mem_read;
         ex_mem_write   <= w_mem_write;
         ex_reg_write   <= w_reg_write;
         ex_is_branch   <= w_branch;
         ex_is_jump     <= w_jump;
         ex_pred_taken  <= w_pred;
         ex_funct3      <= w_funct3;
         ex_illegal     <= w_illegal;
      end
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage directly downstream of the instruction-fetch stage.
- Consumes the IF/ID pipeline register: PC, instruction, predicted-taken flag and valid.
- Holds the 32x32 integer register file, decodes RV32I, generates immediates and detects load-use hazards (stall back to fetch).
- Drives the ID/EX pipeline register.

Parameters:
- XLEN, 32, datapath width.
- NOP_INSTR, 32'h00000013, encoding used for bubbles.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- if_pc  in  32  IF/ID program counter
- if_instr  in  32  IF/ID instruction
- if_pred_taken  in  1  IF branch/jump predicted-taken flag
- if_valid  in  1  IF/ID entry valid
- hazard_flush  in  1  branch/jump redirect, kill ID contents
- wb_we  in  1  writeback write enable
- wb_rd  in  5  writeback destination register
- wb_wdata  in  32  writeback data
- load_use_stall  out  1  combinational stall request to fetch (hazard_stall)
- ex_valid  out  1  ID/EX valid
- ex_pc  out  32  PC
- ex_instr  out  32  instruction (NOP_INSTR on bubble)
- ex_rs1_data, ex_rs2_data  out  32 each  operands
- ex_imm  out  32  sign-extended immediate
- ex_rs1, ex_rs2, ex_rd  out  5 each  register indices
- ex_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- ex_alu_src_imm  out  1  operand B = imm
- ex_alu_src_pc  out  1  operand A = PC (AUIPC, JAL)
- ex_mem_read, ex_mem_write, ex_reg_write  out  1 each  memory/writeback controls
- ex_is_branch, ex_is_jump  out  1 each  control-flow type
- ex_pred_taken  out  1  forwarded prediction
- ex_funct3  out  3  funct3 field
- ex_illegal  out  1  unsupported opcode

Behaviour:
- Reset (async, high):
  - All 32 registers = 0.
  - All ex_* outputs = 0, except ex_instr = NOP_INSTR.
  - Hold register empty.
- Source selection: src = hold_valid ? held {pc, instr, pred} : if_* inputs. src_valid = hold_valid | if_valid.
- Register file:
  - x0 reads 0 and is never written.
  - Write on posedge when wb_we and wb_rd != 0.
  - Read bypass: when wb_we, wb_rd == rs and rs != 0, the read returns wb_wdata in the same cycle.
- Decode by opcode:
  - LUI: I=U-imm, alu PASSB.
  - AUIPC: U-imm, src_pc, ADD.
  - JAL: J-imm, jump, src_pc.
  - JALR: I-imm, jump.
  - BRANCH: B-imm, no reg_write.
  - LOAD: I-imm, mem_read.
  - STORE: S-imm, mem_write.
  - OP-IMM: I-imm; funct3 selects op; SRAI when instr[30].
  - OP: instr[30] selects SUB/SRA.
  - FENCE/SYSTEM: decoded as NOP.
  - Anything else: ex_illegal = 1 with reg_write/mem controls = 0.
- reg_write is forced to 0 when rd == 0.
- Source-register usage:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by BRANCH, STORE and OP.
- load_use_stall = src_valid & !hazard_flush & ex_valid & ex_mem_read & ex_rd != 0 & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd)).
- Per clock edge, highest priority first:
  1. hazard_flush: ex bubble (ex_valid = 0, controls = 0, ex_instr = NOP_INSTR); hold cleared.
  2. load_use_stall: ex bubble; src captured into hold (hold_valid = 1).
  3. src_valid: decoded src latched into ID/EX with ex_valid = 1; hold cleared.
  4. Otherwise: ex bubble.
- Latency: one cycle from IF/ID entry to ID/EX; one bubble cycle per load-use hazard.
- The hold register is required because fetch deasserts if_valid while stalled. The held instruction replays in the next cycle, and the hazard is resolved at that point because EX then contains a bubble.

Test Plan:
- Reset: assert reset mid-stream -> ex_valid = 0, ex_instr = 32'h00000013, x5 reads 0 afterwards.
- ADDI x1,x0,5 (32'h00500093), pc = 0x10 -> next cycle: ex_imm = 5, alu ADD, src_imm = 1, reg_write = 1, rd = 1, ex_pc = 0x10.
- Bypass: wb_we = 1, wb_rd = 3, wb_wdata = 0xDEADBEEF in the same cycle as ADD x4,x3,x3 -> ex_rs1_data = ex_rs2_data = 0xDEADBEEF; write to rd = 0 leaves x0 = 0.
- Load-use: LW x2,0(x1) then ADD x3,x2,x2:
  - Stall asserted for exactly 1 cycle and one bubble issued.
  - ADD issues on the following cycle from hold while if_valid = 0.
- Flush: hazard_flush together with a stall condition -> load_use_stall = 0, bubble, hold cleared, the held instruction never issues.
- BEQ x1,x2,-8 (32'hFE208CE3) with if_pred_taken = 1 -> ex_imm = 0xFFFFFFF8, is_branch = 1, pred_taken = 1, reg_write = 0; opcode 7'h7F -> ex_illegal = 1.
